uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, payload bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud ticks per bit period.
REQ-003 SHALL have parameter BAUD_DIV, default 163, i_clk cycles per baud tick (50 MHz, 19200 baud x16).
REQ-004 SHALL have port i_clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port o_data  output  DATA_BITS  last valid received byte.
REQ-008 SHALL have port o_rx_done  output  1  one-cycle pulse, o_data valid, feeds downstream frame assembler.
REQ-009 SHALL have port o_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port o_parity_err  output  1  one-cycle pulse, parity mismatch.
REQ-011 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass i_rx through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-013 SHALL generate a baud tick: counter 0..BAUD_DIV-1, tick high one cycle when count equals BAUD_DIV-1, then wrap to 0.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; per-bit tick counter 0..OVERSAMPLE-1.
REQ-015 IDLE: on falling edge of synchronized rx (previous 1, current 0) SHALL go START and clear the tick counter; a line held low SHALL NOT start a frame.
REQ-016 START: at tick count OVERSAMPLE/2-1 (mid start bit) SHALL go DATA if rx is 0, else return to IDLE (glitch reject) with no output pulse.
REQ-017 DATA: at tick count OVERSAMPLE-1 SHALL shift rx into the shift register LSB-first; after DATA_BITS samples SHALL go PARITY (macro defined) or STOP.
REQ-018 STOP: at tick count OVERSAMPLE-1 SHALL sample stop bit and return to IDLE.
REQ-019 Valid frame: o_data SHALL update and o_rx_done SHALL pulse for exactly one cycle, the cycle after the stop-bit sample.
REQ-020 Stop bit 0 SHALL pulse o_frame_err instead of o_rx_done; o_data SHALL keep its previous value.
REQ-021 Parity error SHALL pulse o_parity_err instead of o_rx_done; o_data SHALL be unchanged; if stop bit also 0, both error pulses SHALL assert.
REQ-022 o_data SHALL hold its value until the next valid frame.
REQ-023 Back-to-back frames (start bit immediately after stop) SHALL all be received with no lost byte.

Reset
REQ-024 i_reset SHALL force state IDLE, all counters 0, shift register 0, o_data 0, all pulses 0, o_busy 0, synchronizer flops 1.
REQ-025 Reset mid-frame SHALL abort the frame with no output pulse; the next full frame SHALL be received correctly.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY state present, even parity bit checked after data bits.
REQ-027 Macro undefined: PARITY state removed, frame is 1 start + DATA_BITS + 1 stop, o_parity_err tied 0.

Structure
REQ-028 Shared package uart_pkg SHALL hold state encoding, default OVERSAMPLE, default BAUD_DIV.
REQ-029 Baud tick generator SHALL be sub-module uart_baud_gen (parameter BAUD_DIV, output tick), reusable by the TX block.

Verification (bench uses BAUD_DIV=4, OVERSAMPLE=16)
REQ-030 Frame 0x5A, valid stop -> single o_rx_done pulse, o_data=0x5A, o_busy low after.
REQ-031 Back-to-back 0x01, 0xFF, 0x80 -> three o_rx_done pulses, o_data in that order.
REQ-032 rx low for 4 ticks then high -> no pulse, state IDLE, next frame 0x3C received.
REQ-033 Frame 0xA5 with stop bit 0 -> o_frame_err pulse, no o_rx_done, o_data keeps previous value.
REQ-034 Reset asserted at data bit 3 of 0x77, then frame 0x12 -> no pulse for 0x77, o_data=0x12.
REQ-035 Macro defined, 0x07 with parity bit 0 -> o_parity_err pulse, no o_rx_done; parity bit 1 -> o_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default timing parameters.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_BAUD_DIV   = 163;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud tick generator: one-cycle tick every BAUD_DIV clocks.
// Shared between the UART receive and transmit paths.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic tick
);

    localparam int            CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronized input, mid-bit sampling, LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit check after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int            TW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int            BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_next;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 baud_tick;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 fall_edge;
    logic                 at_mid;
    logic                 at_last;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad;
`endif

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .tick    (baud_tick)
    );

    // Synchronizer and edge-detect flops reset to the idle-high line level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall_edge = rx_prev & ~rx_sync;
    assign at_mid    = baud_tick && (tick_cnt == TICK_MID);
    assign at_last   = baud_tick && (tick_cnt == TICK_LAST);
    assign o_busy    = (state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (fall_edge) state_next = ST_START;
            ST_START:  if (at_mid) state_next = rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (at_last && (bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (at_last) state_next = ST_STOP;
`endif
            ST_STOP:   if (at_last) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: the shift register is reset explicitly; it is a handful of flops, not a RAM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
                ST_START: begin
                    if (baud_tick) tick_cnt <= at_mid ? '0 : tick_cnt + TW'(1);
                end
                ST_DATA: begin
                    if (baud_tick) tick_cnt <= at_last ? '0 : tick_cnt + TW'(1);
                    if (at_last) begin
                        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) tick_cnt <= at_last ? '0 : tick_cnt + TW'(1);
                    // Even parity: the parity bit must equal the XOR of the data bits.
                    if (at_last) parity_bad <= rx_sync ^ (^shift_reg);
                end
`endif
                ST_STOP: begin
                    if (baud_tick) tick_cnt <= at_last ? '0 : tick_cnt + TW'(1);
                    if (at_last) begin
                        o_frame_err <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
                        o_parity_err <= parity_bad;
                        if (rx_sync && !parity_bad) begin
`else
                        if (rx_sync) begin
`endif
                            o_data    <= shift_reg;
                            o_rx_done <= 1'b1;
                        end
                    end
                end
                default: tick_cnt <= '0;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BAUD_DIV=4, OVERSAMPLE=16 (64 clocks per bit).
// Parity scenarios run when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int         total;
    int         bad;
    int         done_cnt;
    int         ferr_cnt;
    int         perr_cnt;
    logic [7:0] rx_q[$];

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .BAUD_DIV   (4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx         (rx),
        .o_data       (data),
        .o_rx_done    (rx_done),
        .o_frame_err  (frame_err),
        .o_parity_err (parity_err),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            rx_q.push_back(data);
        end
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rx  = 1'b1;
        rst = 1'b1;
        settle(5);
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", rx_done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        rst = 1'b0;
        settle(20);
    endtask

    task automatic test_single_frame();
        int d0 = done_cnt;
        int f0 = ferr_cnt;
        send_frame(8'h5A, 1'b1);
        settle(40);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (rx_q.size() == 0 || rx_q[rx_q.size()-1] !== 8'h5A) begin bad++; $display("FAIL single_captured: queue size %0d want last 5a", rx_q.size()); end
        total++; if (data !== 8'h5A) begin bad++; $display("FAIL single_data: got %h want 5a", data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", busy); end
        total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int q0 = rx_q.size();
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        settle(40);
        total++; if (done_cnt - d0 !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt - d0); end
        if (rx_q.size() >= q0 + 3) begin
            total++; if (rx_q[q0] !== 8'h01) begin bad++; $display("FAIL b2b_byte0: got %h want 01", rx_q[q0]); end
            total++; if (rx_q[q0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_byte1: got %h want ff", rx_q[q0+1]); end
            total++; if (rx_q[q0+2] !== 8'h80) begin bad++; $display("FAIL b2b_byte2: got %h want 80", rx_q[q0+2]); end
        end
        total++; if (data !== 8'h80) begin bad++; $display("FAIL b2b_data: got %h want 80", data); end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        int f0 = ferr_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        settle(100);
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL glitch_done: got %0d want 0", done_cnt - d0); end
        total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
        send_frame(8'h3C, 1'b1);
        settle(40);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL glitch_next_done: got %0d want 1", done_cnt - d0); end
        total++; if (data !== 8'h3C) begin bad++; $display("FAIL glitch_next_data: got %h want 3c", data); end
    endtask

    task automatic test_frame_err();
        int d0 = done_cnt;
        int f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        settle(100);
        total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL ferr_done: got %0d want 0", done_cnt - d0); end
        total++; if (data !== 8'h3C) begin bad++; $display("FAIL ferr_data_kept: got %h want 3c", data); end
    endtask

    task automatic test_reset_mid_frame();
        int d0 = done_cnt;
        int f0 = ferr_cnt;
        logic [7:0] d77 = 8'h77;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d77[i]);
        rx = d77[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midframe_busy: got %b want 1", busy); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        settle(4);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL abort_data: got %h want 00", data); end
        settle(200);
        total++; if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin bad++; $display("FAIL abort_pulses: got done=%0d ferr=%0d want 0", done_cnt - d0, ferr_cnt - f0); end
        send_frame(8'h12, 1'b1);
        settle(40);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL after_abort_done: got %0d want 1", done_cnt - d0); end
        total++; if (data !== 8'h12) begin bad++; $display("FAIL after_abort_data: got %h want 12", data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par_bit);
        send_bit(1'b1);
        rx = 1'b1;
    endtask

    task automatic test_parity();
        int d0 = done_cnt;
        int p0 = perr_cnt;
        send_frame_par(8'h07, 1'b0);
        settle(40);
        total++; if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL parity_err_count: got %0d want 1", perr_cnt - p0); end
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL parity_err_done: got %0d want 0", done_cnt - d0); end
        total++; if (data !== 8'h12) begin bad++; $display("FAIL parity_err_data: got %h want 12", data); end
        send_frame_par(8'h07, 1'b1);
        settle(40);
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL parity_ok_done: got %0d want 1", done_cnt - d0); end
        total++; if (data !== 8'h07) begin bad++; $display("FAIL parity_ok_data: got %h want 07", data); end
        total++; if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL parity_ok_perr: got %0d want 1", perr_cnt - p0); end
    endtask
`else
    task automatic test_parity();
        total++; if (perr_cnt !== 0) begin bad++; $display("FAIL parity_tied_low: got %0d pulses want 0", perr_cnt); end
    endtask
`endif

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        ferr_cnt = 0;
        perr_cnt = 0;
        rx       = 1'b1;
        rst      = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
